// File: rtl/spu_fetch_buffer.sv
// -----------------------------------------------------------------------------
// spu_fetch_buffer
//
// Instruction-pair fetch buffer for an SPU-style front end. Fetches 8-byte
// aligned instruction pairs from local store, one request in flight at a time,
// and queues them in a small FIFO for decode. A taken branch flushes the FIFO
// and redirects fetch. If the branch target is the odd word of a pair, the
// first instruction of the next delivered pair is marked invalid.
//
// Parameters
//   DEPTH     FIFO entries (power of 2, >= 2)
//   LS_BYTES  local-store size in bytes; the fetch PC wraps modulo this value
//
// Ports
//   clk              sole clock, all state updates on the rising edge
//   reset            asynchronous, active-low reset
//   ls_req           local-store fetch request (registered)
//   ls_addr          8-byte-aligned fetch byte address
//   ls_gnt           request accepted this cycle
//   ls_rvalid        fetch data valid
//   ls_rdata         two instructions; the lower-address one is in [63:32]
//   branch_taken     redirect from execute (odd pipe)
//   branch_target    redirect byte address
//   pair_valid       head pair available to decode
//   pair_ready       decode accepts the head pair
//   pair_instr0      first (even-address) instruction of the head pair
//   pair_instr1      second instruction of the head pair
//   pair_pc          byte address of pair_instr0
//   pair_slot_valid  bit 0: instr0 valid, bit 1: instr1 valid
// -----------------------------------------------------------------------------
module spu_fetch_buffer #(
  parameter int DEPTH    = 4,
  parameter int LS_BYTES = 32768
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ls_req,
  output logic [31:0] ls_addr,
  input  logic        ls_gnt,
  input  logic        ls_rvalid,
  input  logic [63:0] ls_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        pair_valid,
  input  logic        pair_ready,
  output logic [31:0] pair_instr0,
  output logic [31:0] pair_instr1,
  output logic [31:0] pair_pc,
  output logic [1:0]  pair_slot_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [31:0] LS_SIZE = 32'(LS_BYTES);
  localparam logic [31:0] LS_LAST = 32'(LS_BYTES - 8);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // REQ: free to issue; WAIT: response owed and wanted;
  // DISCARD: response owed but belongs to a squashed path.
  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DISCARD
  } state_t;

  typedef struct packed {
    logic [31:0] instr0;
    logic [31:0] instr1;
    logic [31:0] pc;
    logic [1:0]  slot_valid;
  } pair_t;

  state_t             state;
  state_t             state_nxt;
  logic [31:0]        fetch_pc;
  logic [31:0]        req_pc;
  logic               first_slot_kill;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_nxt;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  pair_t              mem [DEPTH];
  pair_t              head;

  logic               gnt_ok;
  logic               enq;
  logic               deq;
  logic [31:0]        pc_inc;
  logic [31:0]        branch_pc;

  // Sequential PC step with wrap at the top of local store.
  assign pc_inc    = (fetch_pc >= LS_LAST) ? 32'd0 : fetch_pc + 32'd8;
  // Redirect address: drop the word/byte offset, then fold into local store.
  assign branch_pc = {branch_target[31:3], 3'b000} % LS_SIZE;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    gnt_ok    = 1'b0;
    enq       = 1'b0;
    deq       = 1'b0;
    state_nxt = state;
    count_nxt = count;

    // A branch overrides grant, enqueue and dequeue in the same cycle.
    gnt_ok = (state == S_REQ) && ls_req && ls_gnt && !branch_taken;
    enq    = (state == S_WAIT) && ls_rvalid && !branch_taken;
    deq    = pair_valid && pair_ready && !branch_taken;

    case (state)
      S_REQ: begin
        if (gnt_ok) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Data arriving together with a branch is dropped, but the response
        // is no longer owed, so go straight back to REQ.
        if (ls_rvalid)         state_nxt = S_REQ;
        else if (branch_taken) state_nxt = S_DISCARD;
      end
      S_DISCARD: begin
        if (ls_rvalid) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase

    if (branch_taken) count_nxt = '0;
    else              count_nxt = count + CNT_W'(enq) - CNT_W'(deq);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_REQ;
      fetch_pc        <= '0;
      req_pc          <= '0;
      first_slot_kill <= 1'b0;
      count           <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      ls_req          <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      // Registered request: reflects the condition of the state being entered.
      ls_req <= (state_nxt == S_REQ) && (count_nxt < CNT_FULL);

      if (branch_taken) begin
        fetch_pc        <= branch_pc;
        first_slot_kill <= branch_target[2];
        wr_ptr          <= '0;
        rd_ptr          <= '0;
      end else begin
        if (gnt_ok) begin
          req_pc   <= fetch_pc;
          fetch_pc <= pc_inc;
        end
        if (enq) begin
          wr_ptr          <= wr_ptr + 1'b1;
          first_slot_kill <= 1'b0;
        end
        if (deq) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

  // NOTE: the pair storage has no reset; an entry is only observed after it is
  // written, since occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= '{
        instr0:     ls_rdata[63:32],
        instr1:     ls_rdata[31:0],
        pc:         req_pc,
        slot_valid: first_slot_kill ? 2'b10 : 2'b11
      };
    end
  end

  assign head       = mem[rd_ptr];
  assign pair_valid = (count != '0);
  assign ls_addr    = fetch_pc;

  // Outputs read as zero while empty, which also keeps them zero in reset.
  assign pair_instr0     = pair_valid ? head.instr0     : '0;
  assign pair_instr1     = pair_valid ? head.instr1     : '0;
  assign pair_pc         = pair_valid ? head.pc         : '0;
  assign pair_slot_valid = pair_valid ? head.slot_valid : '0;

endmodule

// File: doc/spu_fetch_buffer.md
SPU_FETCH_BUFFER -- requirements
Module: spu_fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction-pair FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter LS_BYTES, default 32768, meaning local-store size in bytes; fetch PC wraps modulo LS_BYTES.
REQ-003 SHALL have ports as follows; the design uses one clock and an asynchronous, active-low reset.
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- ls_req  out  1  local-store fetch request.
- ls_addr  out  32  8-byte-aligned fetch byte address.
- ls_gnt  in  1  request accepted this cycle.
- ls_rvalid  in  1  fetch data valid.
- ls_rdata  in  64  two instructions; bits [0:31] are the lower-address instruction.
- branch_taken  in  1  redirect from execute (odd pipe).
- branch_target  in  32  redirect byte address.
- pair_valid  out  1  head pair available to decode.
- pair_ready  in  1  decode accepts head pair.
- pair_instr0  out  32  first (even-address) instruction.
- pair_instr1  out  32  second instruction.
- pair_pc  out  32  byte address of pair_instr0.
- pair_slot_valid  out  2  bit 0: instr0 valid; bit 1: instr1 valid.

Function
REQ-004 SHALL hold fetch_pc (32b), a FIFO of {instr0, instr1, pc, slot_valid} of DEPTH entries, occupancy count (0..DEPTH), and first_slot_kill flag.
REQ-005 SHALL implement FSM states: REQ, WAIT, DISCARD.
REQ-006 REQ state: ls_req=1 iff count + 0 < DEPTH (no outstanding); ls_addr=fetch_pc; on ls_gnt go WAIT, fetch_pc <= (fetch_pc+8) mod LS_BYTES.
REQ-007 WAIT state: ls_req=0; on ls_rvalid enqueue {ls_rdata[0:31], ls_rdata[32:63], pc of request, slot_valid}, go REQ.
REQ-008 slot_valid of an enqueued pair SHALL be 2'b10 (instr0 killed) when first_slot_kill=1, else 2'b11; first_slot_kill clears on that enqueue.
REQ-009 Only one outstanding request; the ls_req condition is count < DEPTH.
REQ-010 pair_valid = (count != 0); pair_* reflect FIFO head combinationally from registered storage; entry written at rvalid is visible the next cycle.
REQ-011 Dequeue occurs when pair_valid && pair_ready; simultaneous enqueue and dequeue leave count unchanged.
REQ-012 pair_ready while empty SHALL be ignored; enqueue while full SHALL not happen (guaranteed by REQ-009).
REQ-013 branch_taken SHALL, in the same edge: empty the FIFO (count<=0), set fetch_pc <= {branch_target[0:28],3'b000} mod LS_BYTES, set first_slot_kill <= branch_target bit 29 (byte address bit 2).
REQ-014 branch_taken takes priority over simultaneous dequeue, enqueue and ls_gnt; data arriving that cycle SHALL be dropped and the grant ignored.
REQ-015 branch_taken in WAIT SHALL go DISCARD; in DISCARD the next ls_rvalid is dropped, then go REQ; ls_req=0 in DISCARD.
REQ-016 branch_taken in REQ or DISCARD SHALL go/remain REQ or DISCARD respectively (DISCARD still owes a response).
REQ-017 ls_addr bits [29:31] SHALL always be 0.
REQ-018 Wrap: fetch_pc = LS_BYTES-8 increments to 0.

Reset
REQ-019 reset low SHALL asynchronously set fetch_pc=0, count=0, FIFO pointers=0, first_slot_kill=0, state=REQ.
REQ-020 During reset all outputs SHALL be 0 except ls_addr=0 and ls_req=0; ls_req may assert the first cycle after reset deasserts.
REQ-021 Reset mid-WAIT SHALL abandon the outstanding request; a later stray ls_rvalid in REQ state SHALL be ignored.

Verification
REQ-022 Reset release, ls_gnt same cycle, rvalid 2 cycles later with rdata=64'h11111111_22222222 -> ls_addr=0, next cycle pair_valid=1, instr0=32'h11111111, instr1=32'h22222222, pc=0, slot_valid=2'b11.
REQ-023 pair_ready=0, grant/rvalid every opportunity -> exactly 4 pairs at pc 0,8,16,24; ls_req=0 while count=4; one dequeue re-enables ls_req with ls_addr=32.
REQ-024 branch_taken with target 32'h0000_0104 while FIFO holds 3 pairs -> pair_valid=0 next cycle, next ls_addr=32'h100, delivered pair slot_valid=2'b10, pc=32'h100.
REQ-025 branch_taken while WAIT, rvalid 1 cycle later -> that data dropped, next ls_addr=target, no stale pair ever on pair_valid.
REQ-026 fetch_pc=32760 (LS_BYTES-8) granted -> next ls_addr=0.
REQ-027 Reset asserted during WAIT, rvalid arrives during/after reset -> FIFO empty, first post-reset ls_addr=0.
